// File: rtl/mba_pkg.sv
// Shared definitions for the modified-Booth (radix-4) multiplier datapath:
// partial-product select codes and the sequencer state encoding.
package mba_pkg;

  localparam logic [1:0] SEL_ZERO   = 2'b00;
  localparam logic [1:0] SEL_M      = 2'b01;
  localparam logic [1:0] SEL_2M     = 2'b10;
  localparam logic [1:0] SEL_UNUSED = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: multiplier triplet -> {sel1, sel0, neg}.
module booth_r4_encoder
  import mba_pkg::*;
(
  input  logic [2:0] i_triplet,
  output logic       o_sel1,
  output logic       o_sel0,
  output logic       o_neg
);

  logic [1:0] w_sel;
  logic       w_neg;

  always_comb begin
    w_sel = SEL_ZERO;
    w_neg = 1'b0;
    case (i_triplet)
      3'b001, 3'b010: begin w_sel = SEL_M;  w_neg = 1'b0; end
      3'b011:         begin w_sel = SEL_2M; w_neg = 1'b0; end
      3'b100:         begin w_sel = SEL_2M; w_neg = 1'b1; end
      3'b101, 3'b110: begin w_sel = SEL_M;  w_neg = 1'b1; end
      default:        begin w_sel = SEL_ZERO; w_neg = 1'b0; end
    endcase
  end

  assign o_sel1 = w_sel[1];
  assign o_sel0 = w_sel[0];
  assign o_neg  = w_neg;

endmodule

// File: rtl/mba_mux4.sv
// Single-bit 4:1 select cell used to build the partial-product selector.
module mba_mux4 (
  input  logic       i_d0,
  input  logic       i_d1,
  input  logic       i_d2,
  input  logic       i_d3,
  input  logic [1:0] i_sel,
  output logic       o_y
);

  always_comb begin
    o_y = 1'b0;
    case (i_sel)
      2'b00:   o_y = i_d0;
      2'b01:   o_y = i_d1;
      2'b10:   o_y = i_d2;
      2'b11:   o_y = i_d3;
      default: o_y = 1'b0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Iterative signed radix-4 Booth multiplier, one Booth digit per clock,
// with a start/busy/done handshake and a fixed WIDTH/2+1 cycle latency.
module booth_r4_seq_mul
  import mba_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int PW  = WIDTH + 2;
  localparam int AW  = 2 * WIDTH + 2;
  localparam int NIT = WIDTH / 2;
  localparam int CW  = $clog2(NIT + 1);

  state_t             r_state;
  state_t             w_next;
  logic [PW-1:0]      r_m;
  logic [WIDTH:0]     r_q;
  logic [AW-1:0]      r_acc;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;
  logic               r_busy;
  logic               r_done;

  logic               w_accept;
  logic               w_sel1;
  logic               w_sel0;
  logic               w_neg;
  logic [PW-1:0]      w_m2;
  logic [PW-1:0]      w_pp_sel;
  logic [PW-1:0]      w_pp_inv;
  logic [AW-1:0]      w_pp_ext;
  logic [AW-1:0]      w_pp_sh;
  logic [AW-1:0]      w_rnd;
  logic [AW-1:0]      w_acc_next;
  logic [CW-1:0]      w_iter;

  assign w_accept = start_i && (r_state != RUN);

  booth_r4_encoder u_enc (
    .i_triplet (r_q[2:0]),
    .o_sel1    (w_sel1),
    .o_sel0    (w_sel0),
    .o_neg     (w_neg)
  );

  assign w_m2 = {r_m[PW-2:0], 1'b0};

  for (genvar b = 0; b < PW; b++) begin : g_ppsel
    mba_mux4 u_mux (
      .i_d0  (1'b0),
      .i_d1  (r_m[b]),
      .i_d2  (w_m2[b]),
      .i_d3  (1'b0),
      .i_sel ({w_sel1, w_sel0}),
      .o_y   (w_pp_sel[b])
    );
  end

  // Negation is invert here plus a +1 at the digit's weight in the same add.
  assign w_pp_inv   = w_pp_sel ^ {PW{w_neg}};
  assign w_pp_ext   = {{(AW-PW){w_pp_inv[PW-1]}}, w_pp_inv};
  assign w_iter     = CW'(NIT) - r_cnt;
  assign w_pp_sh    = w_pp_ext << {w_iter, 1'b0};
  assign w_rnd      = {{(AW-1){1'b0}}, w_neg} << {w_iter, 1'b0};
  assign w_acc_next = r_acc + w_pp_sh + w_rnd;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) w_next = RUN;
        else         w_next = IDLE;
      end
      RUN: begin
        if (r_cnt == CW'(1)) w_next = DONE;
        else                 w_next = RUN;
      end
      DONE: begin
        if (start_i) w_next = RUN;
        else         w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand latch, Booth iteration and registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_m       <= '0;
      r_q       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_busy <= (w_next == RUN);
      r_done <= (w_next == DONE);
      if (w_accept) begin
        r_m   <= {{2{multiplicand_i[WIDTH-1]}}, multiplicand_i};
        r_q   <= {multiplier_i, 1'b0};
        r_acc <= '0;
        r_cnt <= CW'(NIT);
      end else if (r_state == RUN) begin
        r_acc <= w_acc_next;
        r_q   <= {{2{r_q[WIDTH]}}, r_q[WIDTH:2]};
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_product <= w_acc_next[2*WIDTH-1:0];
        end
      end
    end
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign product_o = r_product;

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Self-checking bench for booth_r4_seq_mul: directed table at WIDTH=8,
// handshake corner sequences, recoder table and an exhaustive WIDTH=4 sweep.
module tb_booth_r4_seq_mul;

  logic        clk;
  logic        rst;
  logic        start8;
  logic [7:0]  m8;
  logic [7:0]  q8;
  logic        busy8;
  logic        done8;
  logic [15:0] prod8;

  logic        start4;
  logic [3:0]  m4;
  logic [3:0]  q4;
  logic        busy4;
  logic        done4;
  logic [7:0]  prod4;

  logic [2:0]  enc_t;
  logic        enc_s1;
  logic        enc_s0;
  logic        enc_n;

  int errors = 0;
  int checks = 0;

  booth_r4_seq_mul #(.WIDTH(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start8),
    .multiplicand_i (m8),
    .multiplier_i   (q8),
    .busy_o         (busy8),
    .done_o         (done8),
    .product_o      (prod8)
  );

  booth_r4_seq_mul #(.WIDTH(4)) dut4 (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start4),
    .multiplicand_i (m4),
    .multiplier_i   (q4),
    .busy_o         (busy4),
    .done_o         (done4),
    .product_o      (prod4)
  );

  booth_r4_encoder u_enc_chk (
    .i_triplet (enc_t),
    .o_sel1    (enc_s1),
    .o_sel0    (enc_s0),
    .o_neg     (enc_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    m;
    int    q;
    int    exp;
    string name;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One WIDTH=8 multiply with exact cycle-by-cycle handshake checks.
  task automatic run8(input int m, input int q, input int exp, input string name);
    logic [15:0] prev;
    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic        held;
    prev = prod8;
    held = 1'b1;
    @(negedge clk);
    start8 = 1'b1;
    m8 = 8'(m);
    q8 = 8'(q);
    @(negedge clk);
    start8 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      busy_v[c] = busy8;
      done_v[c] = done8;
      if (prod8 !== prev) held = 1'b0;
      if (c < 3) @(negedge clk);
    end
    chk({name, "_busy_window"}, {28'b0, busy_v}, 32'h0000_000F);
    chk({name, "_no_early_done"}, {28'b0, done_v}, 32'h0000_0000);
    chk({name, "_product_held"}, {31'b0, held}, 32'h0000_0001);
    @(negedge clk);
    chk({name, "_done"}, {30'b0, done8, busy8}, 32'h0000_0002);
    chk({name, "_product"}, {16'b0, prod8}, {16'b0, 16'(exp)});
    @(negedge clk);
    chk({name, "_done_pulse_end"}, {31'b0, done8}, 32'h0000_0000);
  endtask

  initial begin
    logic [2:0] enc_exp [8];
    logic       done_seen;
    logic       exp_busy;
    logic       exp_done;
    int         cyc;
    logic [7:0] exp4;

    tbl[0] = '{7,    3,    21,     "m7_q3"};
    tbl[1] = '{-128, -128, 16384,  "min_min"};
    tbl[2] = '{-128, 127,  -16256, "min_max"};
    tbl[3] = '{-1,   -1,   1,      "neg1_neg1"};
    tbl[4] = '{1,    109,  109,    "recode_6d"};
    tbl[5] = '{0,    -77,  0,      "zero_m"};
    tbl[6] = '{-77,  0,    0,      "zero_q"};
    tbl[7] = '{-128, -1,   128,    "min_neg1"};
    tbl[8] = '{127,  127,  16129,  "max_max"};
    tbl[9] = '{5,    -6,   -30,    "m5_qn6"};

    // sel1, sel0, neg per triplet 000..111
    enc_exp[0] = 3'b000; enc_exp[1] = 3'b010; enc_exp[2] = 3'b010; enc_exp[3] = 3'b100;
    enc_exp[4] = 3'b101; enc_exp[5] = 3'b011; enc_exp[6] = 3'b011; enc_exp[7] = 3'b000;

    rst = 1'b1;
    start8 = 1'b0; m8 = 8'h00; q8 = 8'h00;
    start4 = 1'b0; m4 = 4'h0;  q4 = 4'h0;
    enc_t = 3'b000;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {14'b0, busy8, done8, prod8}, 32'h0000_0000);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run8(tbl[i].m, tbl[i].q, tbl[i].exp, tbl[i].name);
    end

    for (int t = 0; t < 8; t++) begin
      enc_t = 3'(t);
      #1;
      chk($sformatf("encoder_t%0d", t), {29'b0, enc_s1, enc_s0, enc_n}, {29'b0, enc_exp[t]});
    end

    // start held high: relatch only in DONE; a mid-RUN pulse is ignored.
    @(negedge clk);
    start8 = 1'b1; m8 = 8'd5; q8 = 8'd6;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      exp_busy = (n >= 1 && n <= 4) || (n >= 6 && n <= 9);
      exp_done = (n == 5) || (n == 10);
      chk($sformatf("hold_start_n%0d", n), {30'b0, busy8, done8}, {30'b0, exp_busy, exp_done});
      if (exp_done) chk($sformatf("hold_start_prod_n%0d", n), {16'b0, prod8}, 32'd30);
      if (n == 6) start8 = 1'b0;
      if (n == 7) begin start8 = 1'b1; m8 = 8'd3; q8 = 8'd3; end
      if (n == 8) start8 = 1'b0;
    end

    // Reset during the second RUN cycle aborts with no done pulse.
    @(negedge clk);
    start8 = 1'b1; m8 = 8'd9; q8 = 8'd9;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {14'b0, busy8, done8, prod8}, 32'h0000_0000);
    rst = 1'b0;
    done_seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done8) done_seen = 1'b1;
    end
    chk("abort_no_done", {31'b0, done_seen}, 32'h0000_0000);
    run8(9, 9, 81, "after_abort");

    // Exhaustive signed sweep at WIDTH=4: product and fixed latency.
    for (int mi = -8; mi < 8; mi++) begin
      for (int qi = -8; qi < 8; qi++) begin
        @(negedge clk);
        start4 = 1'b1; m4 = 4'(mi); q4 = 4'(qi);
        @(negedge clk);
        start4 = 1'b0;
        cyc = 1;
        while (!done4 && cyc < 10) begin
          @(negedge clk);
          cyc++;
        end
        exp4 = 8'(mi * qi);
        chk($sformatf("sweep_m%0d_q%0d", mi, qi), {16'(cyc), 8'b0, prod4}, {16'd3, 8'b0, exp4});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
